qbu_rx_merge_arb: RTL
=====================

QBU_RX_MERGE_ARB -- requirements
Module: qbu_rx_merge_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, giving the data width in bits; the keep width is DWIDTH/8.
REQ-002 SHALL have ports as listed, one per line below.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_emac_axis_data/user/keep/last/valid  in  DWIDTH/16/DWIDTH/8/1/1  express frame stream from eMAC buffer.
- o_emac_axis_ready  out  1  express stream ready.
- i_emac_no_empty  in  1  eMAC buffer holds a pending frame.
- i_pmac_axis_data/user/keep/last/valid  in  DWIDTH/16/DWIDTH/8/1/1  reassembled preemptable stream.
- o_pmac_axis_ready  out  1  preemptable stream ready.
- o_axis_data/user/keep/last/valid  out  DWIDTH/16/DWIDTH/8/1/1  merged stream.
- i_axis_ready  in  1  downstream ready.
- o_cur_src  out  2  00 none, 01 eMAC, 10 pMAC.
- o_emac_frm_cnt, o_pmac_frm_cnt  out  32 each  forwarded-frame counters.

Function
REQ-003 SHALL implement a registered FSM with states IDLE, EMAC, PMAC; o_cur_src SHALL equal 00, 01 or 10 respectively.
REQ-004 IDLE -> EMAC SHALL occur when i_emac_axis_valid or i_emac_no_empty is high; eMAC SHALL always win over pMAC.
REQ-005 IDLE -> PMAC SHALL occur only when i_pmac_axis_valid is high and both eMAC indications are low.
REQ-006 When i_emac_no_empty is high but i_emac_axis_valid is low, the FSM SHALL stay in EMAC and SHALL NOT grant pMAC.
REQ-007 In EMAC or PMAC, the FSM SHALL return to IDLE on the cycle after a source beat with valid&ready&last; a grant SHALL never change mid-frame.
REQ-008 o_emac_axis_ready SHALL be high only in EMAC, and o_pmac_axis_ready only in PMAC, each gated by skid-not-full; the non-granted ready SHALL be 0.
REQ-009 Accepted beats SHALL pass through a 2-entry skid buffer: data, user, keep and last are forwarded unchanged, and order is preserved.
REQ-010 Latency: a beat accepted at cycle N SHALL appear on o_axis_* at N+1 when i_axis_ready is high.
REQ-011 o_axis_valid SHALL NOT drop while i_axis_ready is low, and o_axis_* SHALL hold stable until the handshake.
REQ-012 There SHALL be one mandatory idle arbitration cycle between frames at the source side; the output side may be back-to-back from skid contents.
REQ-013 A skid entry accepted from a source SHALL remain tagged with that source until output, and frame counters SHALL count on output last handshake.
REQ-014 Counters SHALL be 32-bit and wrap from FFFF_FFFF to 0.
REQ-015 Simultaneous first-beat valid on both sources in IDLE SHALL grant eMAC; the pMAC beat SHALL remain stalled (ready 0) until a later IDLE.

Reset
REQ-016 With i_rst_n low at a clock edge, the FSM SHALL go to IDLE and the skid SHALL empty.
REQ-017 In reset, o_axis_valid, o_axis_last, both source readies, o_cur_src and both counters SHALL be 0; o_axis_data/user/keep SHALL be 0.
REQ-018 Reset mid-frame SHALL discard the partial frame without emitting last; after release the block SHALL restart arbitration from IDLE.

Configuration
REQ-019 With QBU_RX_ARB_STAT_EN defined, the frame counters SHALL operate per REQ-013/014; without it, o_emac_frm_cnt and o_pmac_frm_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-020 Package qbu_rx_pkg SHALL hold the FSM state encoding, the o_cur_src encodings (SRC_NONE, SRC_EMAC, SRC_PMAC) and the counter width constant.
REQ-021 The 2-entry skid buffer SHALL be a sub-module named qbu_rx_axis_skid, parameterised by DWIDTH.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Single eMAC frame of 64 beats, i_axis_ready=1 -> 64 output beats, last on beat 64, o_cur_src=01 throughout, emac_frm_cnt=1.
- pMAC frame of 100 beats in progress when eMAC valid rises at beat 10 -> pMAC completes all 100 beats, then eMAC frame follows with no interleave.
- Both valid in IDLE on the same cycle -> eMAC is granted, o_pmac_axis_ready=0 until eMAC last plus 1 idle cycle.
- i_emac_no_empty=1 with eMAC valid low for 5 cycles while pMAC is valid -> o_pmac_axis_ready stays 0 and the FSM stays in EMAC.
- i_axis_ready toggled 1/0 every cycle over a 20-beat frame -> all 20 beats are delivered in order, o_axis_* stable during stalls, and source ready drops when the skid is full.
- i_rst_n low at beat 7 of a 30-beat frame -> outputs are 0 the next cycle, no last is emitted, and the next frame after release is forwarded intact.

Source files
------------

// File: rtl/qbu_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qbu_rx_pkg : shared encodings for the QBU receive merge arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package qbu_rx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_EMAC = 2'b01;
  localparam state_t ST_PMAC = 2'b10;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_EMAC = 2'b01;
  localparam logic [1:0] SRC_PMAC = 2'b10;

  // Per-entry source tag carried through the skid buffer.
  localparam logic TAG_EMAC = 1'b0;
  localparam logic TAG_PMAC = 1'b1;

  localparam int CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/qbu_rx_axis_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qbu_rx_axis_skid : 2-entry registered AXI-Stream FIFO with src tag   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module qbu_rx_axis_skid #(
  parameter int DWIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [DWIDTH-1:0]   i_data,
  input  logic [15:0]         i_user,
  input  logic [DWIDTH/8-1:0] i_keep,
  input  logic                i_last,
  input  logic                i_tag,
  output logic                o_full,
  output logic                o_valid,
  output logic [DWIDTH-1:0]   o_data,
  output logic [15:0]         o_user,
  output logic [DWIDTH/8-1:0] o_keep,
  output logic                o_last,
  output logic                o_tag,
  input  logic                i_ready
);

  localparam int KW = DWIDTH / 8;
  localparam int EW = DWIDTH + 16 + KW + 2;

  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign o_full  = (cnt_q == 2'd2);
  assign o_valid = (cnt_q != 2'd0);
  assign push    = i_push && !o_full;
  assign pop     = o_valid && i_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {i_tag, i_last, i_keep, i_user, i_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Fields read as zero whenever no beat is presented.
  assign head = o_valid ? mem_q[rd_ptr_q] : '0;
  assign {o_tag, o_last, o_keep, o_user, o_data} = head;

endmodule
`default_nettype wire

// File: rtl/qbu_rx_merge_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qbu_rx_merge_arb : frame-atomic eMAC/pMAC merge, express priority    |
// | Optional frame counters: QBU_RX_ARB_STAT_EN.        Rev 1.0          |
// +----------------------------------------------------------------------+
module qbu_rx_merge_arb
  import qbu_rx_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DWIDTH-1:0]   i_emac_axis_data,
  input  logic [15:0]         i_emac_axis_user,
  input  logic [DWIDTH/8-1:0] i_emac_axis_keep,
  input  logic                i_emac_axis_last,
  input  logic                i_emac_axis_valid,
  output logic                o_emac_axis_ready,
  input  logic                i_emac_no_empty,
  input  logic [DWIDTH-1:0]   i_pmac_axis_data,
  input  logic [15:0]         i_pmac_axis_user,
  input  logic [DWIDTH/8-1:0] i_pmac_axis_keep,
  input  logic                i_pmac_axis_last,
  input  logic                i_pmac_axis_valid,
  output logic                o_pmac_axis_ready,
  output logic [DWIDTH-1:0]   o_axis_data,
  output logic [15:0]         o_axis_user,
  output logic [DWIDTH/8-1:0] o_axis_keep,
  output logic                o_axis_last,
  output logic                o_axis_valid,
  input  logic                i_axis_ready,
  output logic [1:0]          o_cur_src,
  output logic [31:0]         o_emac_frm_cnt,
  output logic [31:0]         o_pmac_frm_cnt
);

  localparam int KW = DWIDTH / 8;

  state_t            state_q, state_d;
  logic              skid_full;
  logic              sel_pmac;
  logic              in_push;
  logic [DWIDTH-1:0] in_data;
  logic [15:0]       in_user;
  logic [KW-1:0]     in_keep;
  logic              in_last;
  logic              in_tag;
  logic              out_tag;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant is held until its source hands over the last beat of the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_emac_axis_valid || i_emac_no_empty) begin
          state_d = ST_EMAC;
        end else if (i_pmac_axis_valid) begin
          state_d = ST_PMAC;
        end
      end
      ST_EMAC: begin
        if (i_emac_axis_valid && o_emac_axis_ready && i_emac_axis_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_PMAC: begin
        if (i_pmac_axis_valid && o_pmac_axis_ready && i_pmac_axis_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_emac_axis_ready = 1'b0;
    o_pmac_axis_ready = 1'b0;
    o_cur_src         = SRC_NONE;
    case (state_q)
      ST_EMAC: begin
        o_emac_axis_ready = !skid_full;
        o_cur_src         = SRC_EMAC;
      end
      ST_PMAC: begin
        o_pmac_axis_ready = !skid_full;
        o_cur_src         = SRC_PMAC;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_pmac = (state_q == ST_PMAC);
    in_push  = (i_emac_axis_valid && o_emac_axis_ready) ||
               (i_pmac_axis_valid && o_pmac_axis_ready);
    in_data  = sel_pmac ? i_pmac_axis_data : i_emac_axis_data;
    in_user  = sel_pmac ? i_pmac_axis_user : i_emac_axis_user;
    in_keep  = sel_pmac ? i_pmac_axis_keep : i_emac_axis_keep;
    in_last  = sel_pmac ? i_pmac_axis_last : i_emac_axis_last;
    in_tag   = sel_pmac ? TAG_PMAC : TAG_EMAC;
  end

  qbu_rx_axis_skid #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (in_push),
    .i_data  (in_data),
    .i_user  (in_user),
    .i_keep  (in_keep),
    .i_last  (in_last),
    .i_tag   (in_tag),
    .o_full  (skid_full),
    .o_valid (o_axis_valid),
    .o_data  (o_axis_data),
    .o_user  (o_axis_user),
    .o_keep  (o_axis_keep),
    .o_last  (o_axis_last),
    .o_tag   (out_tag),
    .i_ready (i_axis_ready)
  );

`ifdef QBU_RX_ARB_STAT_EN
  logic [CNT_W-1:0] emac_cnt_q, emac_cnt_d;
  logic [CNT_W-1:0] pmac_cnt_q, pmac_cnt_d;
  logic             out_last_hs;

  // Frames are credited when their last beat leaves, to the tagged source.
  assign out_last_hs = o_axis_valid && i_axis_ready && o_axis_last;

  always_comb begin
    emac_cnt_d = emac_cnt_q;
    pmac_cnt_d = pmac_cnt_q;
    if (out_last_hs) begin
      if (out_tag == TAG_PMAC) begin
        pmac_cnt_d = pmac_cnt_q + CNT_W'(1);
      end else begin
        emac_cnt_d = emac_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      emac_cnt_q <= '0;
      pmac_cnt_q <= '0;
    end else begin
      emac_cnt_q <= emac_cnt_d;
      pmac_cnt_q <= pmac_cnt_d;
    end
  end

  assign o_emac_frm_cnt = emac_cnt_q;
  assign o_pmac_frm_cnt = pmac_cnt_q;
`else
  logic unused_out_tag;

  assign unused_out_tag = out_tag;
  assign o_emac_frm_cnt = '0;
  assign o_pmac_frm_cnt = '0;
`endif

endmodule
`default_nettype wire
